// File: rtl/wb_regfile_pkg.sv
// Shared definitions for the writeback stage and register file:
// datapath/index widths, ALU control codes, the MEM/WB entry payload,
// the decoded write request and the decode helper used by wb_regfile.
package wb_regfile_pkg;

  localparam int unsigned DW      = 16;
  localparam int unsigned NREG    = 16;
  localparam int unsigned AW      = 4;
  localparam int unsigned CW      = 4;
  localparam int unsigned R15_IDX = 15;

  localparam logic [CW-1:0] CTRL_ADD  = 4'b0000;
  localparam logic [CW-1:0] CTRL_SUB  = 4'b0001;
  localparam logic [CW-1:0] CTRL_MUL  = 4'b0010;
  localparam logic [CW-1:0] CTRL_DIV  = 4'b0011;
  localparam logic [CW-1:0] CTRL_AND  = 4'b0100;
  localparam logic [CW-1:0] CTRL_OR   = 4'b0111;
  localparam logic [CW-1:0] CTRL_LDST = 4'b1000;

  // One MEM/WB pipeline entry as latched from the execute/memory stages.
  typedef struct packed {
    logic          valid;
    logic          regwrite;
    logic [CW-1:0] ctrl;
    logic [AW-1:0] rd;
    logic [DW-1:0] op1;
    logic [DW-1:0] r15;
    logic [DW-1:0] mem;
  } mw_entry_t;

  // Register-file writes implied by one MEM/WB entry.
  typedef struct packed {
    logic          rd_we;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          r15_we;
    logic [DW-1:0] r15_data;
  } wr_req_t;

  // Decode an entry into its writes; applies the R0 and R15-collision rules.
  function automatic wr_req_t wb_decode(input mw_entry_t e);
    wr_req_t r;
    r         = '0;
    r.rd_addr = e.rd;
    case (e.ctrl)
      CTRL_ADD, CTRL_SUB, CTRL_AND, CTRL_OR: begin
        r.rd_we   = e.regwrite;
        r.rd_data = e.op1;
      end
      CTRL_LDST: begin
        r.rd_we   = e.regwrite;
        r.rd_data = e.mem;
      end
      CTRL_MUL, CTRL_DIV: begin
        r.rd_we    = e.regwrite;
        r.rd_data  = e.op1;
        r.r15_we   = 1'b1;
        r.r15_data = e.r15;
      end
      default: ;
    endcase
    if (!e.valid) begin
      r.rd_we  = 1'b0;
      r.r15_we = 1'b0;
    end
    // The secondary result owns R15 when both target it.
    if (r.r15_we && (e.rd == AW'(R15_IDX))) r.rd_we = 1'b0;
    if (e.rd == '0) r.rd_we = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/wb_regfile_core.sv
// 16 x DW architectural register array.
// Ports: clk, rst_n (async active-low, clears all registers);
//   we_a/waddr_a/wdata_a  primary write port (writes to R0 discarded);
//   we_b/wdata_b          dedicated R15 write port, wins over port A on R15;
//   raddr_a/raddr_b -> rdata_a/rdata_b  asynchronous reads, R0 reads 0.
module wb_regfile_core
  import wb_regfile_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_a,
  input  logic [AW-1:0] waddr_a,
  input  logic [DW-1:0] wdata_a,
  input  logic          we_b,
  input  logic [DW-1:0] wdata_b,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] regs [NREG];

  // Array storage; R15 port applied last so it takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (we_a && (waddr_a != '0)) regs[waddr_a] <= wdata_a;
      if (we_b) regs[AW'(R15_IDX)] <= wdata_b;
    end
  end

  // Asynchronous reads with R0 hardwired to zero.
  always_comb begin
    rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
    rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: one-entry MEM/WB register, write decode, commit to the
// register file, retired-instruction counter and two decode read ports.
// Ports: clk, rst_n (async active-low); wb_valid_i, wb_regwrite_i,
//   wb_ctrl_i, wb_rd_i, wb_op1_i, wb_r15_i, wb_mem_i  incoming result;
//   stall_i holds MEM/WB (no capture, no commit);
//   ra_a_i/ra_b_i -> rd_a_o/rd_b_o  combinational read data;
//   retired_o  wrapping count of committed instructions.
// Optional: define WB_BYPASS_EN to forward the pending MEM/WB write to the
//   read ports; otherwise reads see array contents only.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wb_valid_i,
  input  logic          wb_regwrite_i,
  input  logic [3:0]    wb_ctrl_i,
  input  logic [3:0]    wb_rd_i,
  input  logic [DW-1:0] wb_op1_i,
  input  logic [DW-1:0] wb_r15_i,
  input  logic [DW-1:0] wb_mem_i,
  input  logic          stall_i,
  input  logic [3:0]    ra_a_i,
  input  logic [3:0]    ra_b_i,
  output logic [DW-1:0] rd_a_o,
  output logic [DW-1:0] rd_b_o,
  output logic [15:0]   retired_o
);

  mw_entry_t     mw_q;
  mw_entry_t     mw_in_c;
  wr_req_t       req_c;
  logic          commit_c;
  logic [DW-1:0] arr_a_c;
  logic [DW-1:0] arr_b_c;

  always_comb begin
    mw_in_c          = '0;
    mw_in_c.valid    = wb_valid_i;
    mw_in_c.regwrite = wb_regwrite_i;
    mw_in_c.ctrl     = wb_ctrl_i;
    mw_in_c.rd       = wb_rd_i;
    mw_in_c.op1      = wb_op1_i;
    mw_in_c.r15      = wb_r15_i;
    mw_in_c.mem      = wb_mem_i;
  end

  // MEM/WB register: captures every unstalled edge, holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mw_q <= '0;
    else if (!stall_i) mw_q <= mw_in_c;
  end

  always_comb begin
    req_c    = wb_decode(mw_q);
    commit_c = mw_q.valid & ~stall_i;
  end

  // Retired counter; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retired_o <= '0;
    else if (commit_c) retired_o <= retired_o + 16'd1;
  end

  wb_regfile_core u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_a    (commit_c & req_c.rd_we),
    .waddr_a (req_c.rd_addr),
    .wdata_a (req_c.rd_data),
    .we_b    (commit_c & req_c.r15_we),
    .wdata_b (req_c.r15_data),
    .raddr_a (ra_a_i),
    .raddr_b (ra_b_i),
    .rdata_a (arr_a_c),
    .rdata_b (arr_b_c)
  );

`ifdef WB_BYPASS_EN
  // Forward the pending write (stall-independent); R15 port checked first
  // so the collision rule matches the committed result. R0 never forwards.
  function automatic logic [DW-1:0] fwd(input logic [AW-1:0] a,
                                        input logic [DW-1:0] arr);
    logic [DW-1:0] v;
    v = arr;
    if (a != '0) begin
      if (req_c.r15_we && (a == AW'(R15_IDX))) v = req_c.r15_data;
      else if (req_c.rd_we && (a == req_c.rd_addr)) v = req_c.rd_data;
    end
    return v;
  endfunction

  always_comb begin
    rd_a_o = fwd(ra_a_i, arr_a_c);
    rd_b_o = fwd(ra_b_i, arr_b_c);
  end
`else
  always_comb begin
    rd_a_o = arr_a_c;
    rd_b_o = arr_b_c;
  end
`endif

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic        wb_valid_i;
  logic        wb_regwrite_i;
  logic [3:0]  wb_ctrl_i;
  logic [3:0]  wb_rd_i;
  logic [15:0] wb_op1_i;
  logic [15:0] wb_r15_i;
  logic [15:0] wb_mem_i;
  logic        stall_i;
  logic [3:0]  ra_a_i;
  logic [3:0]  ra_b_i;
  logic [15:0] rd_a_o;
  logic [15:0] rd_b_o;
  logic [15:0] retired_o;

  int checks = 0;
  int errors = 0;

  wb_regfile dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wb_valid_i    (wb_valid_i),
    .wb_regwrite_i (wb_regwrite_i),
    .wb_ctrl_i     (wb_ctrl_i),
    .wb_rd_i       (wb_rd_i),
    .wb_op1_i      (wb_op1_i),
    .wb_r15_i      (wb_r15_i),
    .wb_mem_i      (wb_mem_i),
    .stall_i       (stall_i),
    .ra_a_i        (ra_a_i),
    .ra_b_i        (ra_b_i),
    .rd_a_o        (rd_a_o),
    .rd_b_o        (rd_b_o),
    .retired_o     (retired_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_check(input string tag, input logic [3:0] addr, input logic [15:0] exp);
    ra_a_i = addr;
    #1;
    check(tag, rd_a_o, exp);
  endtask

  task automatic issue(input logic rw, input logic [3:0] ctrl, input logic [3:0] rd,
                       input logic [15:0] op1, input logic [15:0] r15, input logic [15:0] mem);
    wb_valid_i    = 1'b1;
    wb_regwrite_i = rw;
    wb_ctrl_i     = ctrl;
    wb_rd_i       = rd;
    wb_op1_i      = op1;
    wb_r15_i      = r15;
    wb_mem_i      = mem;
  endtask

  // Issue, capture, then commit with a bubble behind it.
  task automatic run(input logic rw, input logic [3:0] ctrl, input logic [3:0] rd,
                     input logic [15:0] op1, input logic [15:0] r15, input logic [15:0] mem);
    issue(rw, ctrl, rd, op1, r15, mem);
    tick();
    wb_valid_i = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    wb_valid_i = 1'b0; wb_regwrite_i = 1'b0; wb_ctrl_i = 4'h0; wb_rd_i = 4'h0;
    wb_op1_i = 16'h0; wb_r15_i = 16'h0; wb_mem_i = 16'h0;
    stall_i = 1'b0; ra_a_i = 4'h0; ra_b_i = 4'h0;
    tick();
    tick();
    rst_n = 1'b1;
    check("reset_retired", retired_o, 16'h0000);
    rd_check("reset_r3", 4'd3, 16'h0000);

    // ADD: visible only after the second edge
    issue(1'b1, 4'b0000, 4'd3, 16'h1234, 16'h0, 16'h0);
    tick();
    wb_valid_i = 1'b0;
    rd_check("add_r3_one_edge", 4'd3, 16'h0000);
    check("add_retired_one_edge", retired_o, 16'h0000);
    tick();
    rd_check("add_r3", 4'd3, 16'h1234);
    check("add_retired", retired_o, 16'h0001);

    // MUL writes rd and R15 together
    run(1'b1, 4'b0010, 4'd4, 16'h5678, 16'h0012, 16'h0);
    rd_check("mul_r4", 4'd4, 16'h5678);
    rd_check("mul_r15", 4'd15, 16'h0012);
    check("mul_retired", retired_o, 16'h0002);

    // MUL collision on R15: secondary result wins
    run(1'b1, 4'b0010, 4'd15, 16'hAAAA, 16'h0001, 16'h0);
    rd_check("mul_collision_r15", 4'd15, 16'h0001);
    check("mul_collision_retired", retired_o, 16'h0003);

    // Load to R0 discarded, load to R7 lands
    run(1'b1, 4'b1000, 4'd0, 16'h0, 16'h0, 16'hBEEF);
    rd_check("ld_r0", 4'd0, 16'h0000);
    check("ld_r0_retired", retired_o, 16'h0004);
    run(1'b1, 4'b1000, 4'd7, 16'h1111, 16'h0, 16'hBEEF);
    rd_check("ld_r7", 4'd7, 16'hBEEF);
    check("ld_r7_retired", retired_o, 16'h0005);

    // Undefined ctrl: no register change, still retires
    run(1'b1, 4'b1111, 4'd3, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    rd_check("bad_ctrl_r3", 4'd3, 16'h1234);
    rd_check("bad_ctrl_r15", 4'd15, 16'h0001);
    check("bad_ctrl_retired", retired_o, 16'h0006);

    // Stall holds the captured ADD for three edges
    issue(1'b1, 4'b0000, 4'd2, 16'h0042, 16'h0, 16'h0);
    tick();
    wb_valid_i = 1'b0;
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      rd_check("stall_r2", 4'd2, 16'h0000);
      check("stall_retired", retired_o, 16'h0006);
    end
    stall_i = 1'b0;
    tick();
    rd_check("unstall_r2", 4'd2, 16'h0042);
    check("unstall_retired", retired_o, 16'h0007);

    // DIV with regwrite=0: R15 still written, rd not
    run(1'b0, 4'b0011, 4'd6, 16'h1111, 16'h0BAD, 16'h0);
    rd_check("div_norw_r6", 4'd6, 16'h0000);
    rd_check("div_norw_r15", 4'd15, 16'h0BAD);
    check("div_norw_retired", retired_o, 16'h0008);

    // Reset with a pending valid entry discards it
    issue(1'b1, 4'b0000, 4'd9, 16'h9999, 16'h0, 16'h0);
    tick();
    wb_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_retired", retired_o, 16'h0000);
    rd_check("rst_r3", 4'd3, 16'h0000);
    rd_check("rst_r7", 4'd7, 16'h0000);
    tick();
    rst_n = 1'b1;
    tick();
    rd_check("rst_r9_no_commit", 4'd9, 16'h0000);
    check("rst_retired_after", retired_o, 16'h0000);

    // Same-cycle read of a pending DIV
    issue(1'b1, 4'b0011, 4'd5, 16'h0003, 16'h0001, 16'h0);
    tick();
    wb_valid_i = 1'b0;
    ra_a_i = 4'd5;
    ra_b_i = 4'd15;
    #1;
`ifdef WB_BYPASS_EN
    check("byp_rd_a", rd_a_o, 16'h0003);
    check("byp_rd_b", rd_b_o, 16'h0001);
`else
    check("nobyp_rd_a", rd_a_o, 16'h0000);
    check("nobyp_rd_b", rd_b_o, 16'h0000);
`endif
    tick();
    rd_check("div_r5", 4'd5, 16'h0003);
    ra_b_i = 4'd15;
    #1;
    check("div_r15", rd_b_o, 16'h0001);
    check("div_retired", retired_o, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback stage plus architectural register file for the 16-bit pipeline.
- Consumes the execute-stage results (primary result, secondary R15 result, ALU control code), plus load data from the memory stage.
- Holds them in a one-entry MEM/WB register, then commits to a 16x16 register file.
- Serves two asynchronous read ports to decode.

Parameters:
- DW, 16, datapath width.
- NREG, 16, number of registers (address width = log2(NREG) = 4).
- R15_IDX, 15, index of the secondary-result register.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wb_valid_i  in  1  upstream result valid this cycle.
- wb_regwrite_i  in  1  instruction writes rd.
- wb_ctrl_i  in  4  ALU control code of the instruction.
- wb_rd_i  in  4  destination register.
- wb_op1_i  in  DW  primary ALU result.
- wb_r15_i  in  DW  secondary result (upper product or remainder).
- wb_mem_i  in  DW  load data.
- stall_i  in  1  hold MEM/WB register; no capture, no commit.
- ra_a_i, ra_b_i  in  4  read addresses.
- rd_a_o, rd_b_o  out  DW  read data (combinational).
- retired_o  out  16  count of committed instructions, wraps.

Behaviour:
- Reset (async, rst_n=0):
  - All registers 0.
  - MEM/WB valid=0.
  - retired_o=0.
  - Reads return 0 while in reset.
- Capture:
  - At the rising edge with stall_i=0, MEM/WB latches all wb_* inputs, including valid.
  - With stall_i=1 the MEM/WB contents hold.
- Commit:
  - At the edge after capture, when MEM/WB valid=1 and stall_i=0, the latched instruction writes the register file.
  - Capture of the next instruction happens at the same edge.
  - Latency: input to architectural state is 2 edges.
- Write decode (ctrl held in MEM/WB):
  - 0000, 0001, 0100, 0111 -> rd <= op1.
  - 1000 -> rd <= mem data.
  - 0010, 0011 -> rd <= op1 and R15 <= r15 value, in the same edge.
  - Any other code -> no write.
  - rd writes are gated by regwrite=1. The R15 write for 0010/0011 happens regardless of regwrite.
- R0 is hardwired zero: writes are discarded and reads return 0.
- Collision (rd==15 with 0010/0011): R15 takes the r15 value; the op1 write to R15 is dropped.
- retired_o increments by 1 per commit and wraps FFFF->0000. It does not increment on stalled cycles or invalid entries.
- Reads:
  - Combinational from the array; address 0 returns 0.
  - A same-edge write is not visible until after the edge, unless WB_BYPASS_EN is defined.
- Reset mid-operation discards the pending MEM/WB entry; no commit occurs.
- stall_i=1 with valid entry: no commit, counter held, entry committed on the first edge with stall_i=0.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - Read ports forward the pending MEM/WB write when MEM/WB valid=1 and the address matches.
  - The forwarded value is rd's data, or R15's r15 value per the decode and collision rules above.
  - R0 is never forwarded.
  - Forwarding applies regardless of stall_i.
- Undefined: reads return array contents only. Decode inserts a bubble for a read that depends on the pending write.

Decomposition:
- Shared package:
  - ALU control code constants (ADD=0000, SUB=0001, MUL=0010, DIV=0011, AND=0100, OR=0111, LDST=1000).
  - DW and register-index constants.
  - R15_IDX.
- One natural sub-module: regfile_core, holding the 16xDW array, write ports (primary + R15) and async read ports with R0 forcing.
- wb_regfile holds MEM/WB, decode, collision, bypass and the counter.

Test Plan:
- Reset: drive rst_n=0 mid-run with a pending valid entry -> all reads 0, retired_o=0, no write after release.
- ADD: ctrl=0000, rd=3, op1=0x1234 -> R3=0x1234 after 2 edges; retired_o=1.
- MUL: ctrl=0010, rd=4, op1=0x5678, r15=0x0012 -> R4=0x5678 and R15=0x0012 at the same edge. Then rd=15 with op1=0xAAAA, r15=0x0001 -> R15=0x0001.
- R0 and load: ctrl=1000, rd=0, mem=0xBEEF -> R0 reads 0. Then rd=7, mem=0xBEEF -> R7=0xBEEF. Then ctrl=1111 with regwrite=1 -> no register change, retired_o still increments.
- Stall: valid ADD rd=2 op1=0x0042, stall_i held 3 cycles -> R2 unchanged and retired_o unchanged; R2=0x0042 on the first unstalled edge.
- Bypass (WB_BYPASS_EN defined): pending DIV rd=5 op1=0x0003 r15=0x0001, read ra_a=5, ra_b=15 in the same cycle -> rd_a=0x0003, rd_b=0x0001. Undefined -> old values 0x0000.
